// File: rtl/y_alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and counter sizing.
package y_alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_RSVD = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // One extra bit so the counter can reach WIDTH without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/y_iter_step.sv
// One iteration of the iterative datapath: shift-add multiply step and, when
// Y_SEQ_ALU_DIV_EN is defined, a restoring-divide step selected by div_i.
module y_iter_step #(
  parameter int WIDTH = 32
) (
`ifdef Y_SEQ_ALU_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  // Multiplier sits in lo and is consumed LSB first while the sum shifts in from the top.
  assign mul_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo_i[WIDTH-1:1]};

`ifdef Y_SEQ_ALU_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             qbit;

  // Remainder in hi, dividend/quotient shift register in lo; no borrow means the bit is 1.
  assign rem_sh = {hi_i, lo_i[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, m_i};
  assign qbit   = ~diff[WIDTH];

  assign hi_o = div_i ? (qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]) : mul_hi;
  assign lo_o = div_i ? {lo_i[WIDTH-2:0], qbit} : mul_lo;
`else
  assign hi_o = mul_hi;
  assign lo_o = mul_lo;
`endif

endmodule

// File: rtl/y_seq_alu.sv
// Multi-cycle ALU: registered one-cycle ops plus iterative mul and optional divu
// (enabled by defining Y_SEQ_ALU_DIV_EN) behind a start/busy/done handshake.
module y_seq_alu
  import y_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] zhi,
  output logic             zero,
  output logic             err
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mc_q, mc_d;
  logic [WIDTH-1:0] z_q, z_d, zhi_q, zhi_d;
  logic             zero_q, zero_d, err_q, err_d;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   alu_r;

  // Returns {err, result} for the single-cycle ops; anything else reports err.
  function automatic logic [WIDTH:0] alu_one_cycle(input logic [2:0] o,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] xs, ys;
    logic [WIDTH-1:0]        r;
    logic                    e;
    xs = x;
    ys = y;
    r  = '0;
    e  = 1'b0;
    case (o)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (xs < ys)};
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  assign alu_r = alu_one_cycle(op, a, b);

`ifdef Y_SEQ_ALU_DIV_EN
  logic div_q, div_d;
`endif

  y_iter_step #(.WIDTH(WIDTH)) u_step (
`ifdef Y_SEQ_ALU_DIV_EN
    .div_i (div_q),
`endif
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .m_i   (mc_q),
    .hi_o  (step_hi),
    .lo_o  (step_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mc_d    = mc_q;
    z_d     = z_q;
    zhi_d   = zhi_q;
    zero_d  = zero_q;
    err_d   = err_q;
`ifdef Y_SEQ_ALU_DIV_EN
    div_d   = div_q;
`endif
    case (state_q)
      RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          z_d     = step_lo;
          zhi_d   = step_hi;
          zero_d  = (step_lo == '0);
          err_d   = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE accept a new request identically, so back-to-back has no bubble.
        state_d = IDLE;
        if (start) begin
          if (op == OP_MUL) begin
            state_d = RUN;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = b;
            mc_d    = a;
`ifdef Y_SEQ_ALU_DIV_EN
            div_d   = 1'b0;
          end else if (op == OP_DIVU) begin
            if (b == '0) begin
              state_d = DONE;
              z_d     = '1;
              zhi_d   = a;
              zero_d  = 1'b0;
              err_d   = 1'b1;
            end else begin
              state_d = RUN;
              cnt_d   = '0;
              hi_d    = '0;
              lo_d    = a;
              mc_d    = b;
              div_d   = 1'b1;
            end
`endif
          end else begin
            state_d = DONE;
            z_d     = alu_r[WIDTH-1:0];
            zhi_d   = '0;
            zero_d  = (alu_r[WIDTH-1:0] == '0);
            err_d   = alu_r[WIDTH];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      z_q     <= '0;
      zhi_q   <= '0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      zhi_q   <= zhi_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // Working registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
    mc_q <= mc_d;
`ifdef Y_SEQ_ALU_DIV_EN
    div_q <= div_d;
`endif
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign z    = z_q;
  assign zhi  = zhi_q;
  assign zero = zero_q;
  assign err  = err_q;

endmodule

// File: tb/tb_y_seq_alu.sv
// Scoreboard bench for y_seq_alu: a 32-bit and an 8-bit instance, directed vectors.
module tb_y_seq_alu;

  typedef struct {
    logic [31:0] z;
    logic [31:0] zhi;
    logic        zero;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          cyc;
  int          checks;
  int          fails;

  logic        start32, busy32, done32, zero32, err32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, z32, zhi32;

  logic        start8, busy8, done8, zero8, err8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, z8, zhi8;

  exp_t        q32[$];
  exp_t        q8[$];
  exp_t        e32, e8;
  int          busy_cnt32;
  int          done_cnt32;

  y_seq_alu #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .z(z32), .zhi(zhi32), .zero(zero32), .err(err32)
  );

  y_seq_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .z(z8), .zhi(zhi8), .zero(zero8), .err(err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h want=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (busy32 === 1'b1) busy_cnt32++;
    if (done32 === 1'b1) begin
      done_cnt32++;
      if (q32.size() == 0) begin
        chk("u32_unexpected_done", {31'b0, done32}, 32'd0);
      end else begin
        e32 = q32.pop_front();
        chk("u32_z",    z32, e32.z);
        chk("u32_zhi",  zhi32, e32.zhi);
        chk("u32_zero", {31'b0, zero32}, {31'b0, e32.zero});
        chk("u32_err",  {31'b0, err32}, {31'b0, e32.err});
        chk("u32_done_cycle", cyc, e32.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        chk("u8_unexpected_done", {31'b0, done8}, 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("u8_z",    {24'b0, z8}, e8.z);
        chk("u8_zhi",  {24'b0, zhi8}, e8.zhi);
        chk("u8_zero", {31'b0, zero8}, {31'b0, e8.zero});
        chk("u8_err",  {31'b0, err8}, {31'b0, e8.err});
        chk("u8_done_cycle", cyc, e8.cyc);
      end
    end
  end

  task automatic issue32(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] ez, input logic [31:0] ezhi, input logic eerr,
                         input int lat);
    exp_t e;
    @(negedge clk);
    op32 = o; a32 = ia; b32 = ib; start32 = 1'b1;
    e.z = ez; e.zhi = ezhi; e.zero = (ez == 32'd0); e.err = eerr; e.cyc = cyc + 1 + lat;
    q32.push_back(e);
    @(posedge clk);
    #1 start32 = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [31:0] ez, input logic [31:0] ezhi, input logic eerr,
                        input int lat, input bit hold);
    exp_t e;
    @(negedge clk);
    op8 = o; a8 = ia; b8 = ib; start8 = 1'b1;
    e.z = ez; e.zhi = ezhi; e.zero = (ez == 32'd0); e.err = eerr; e.cyc = cyc + 1 + lat;
    q8.push_back(e);
    @(posedge clk);
    if (!hold) #1 start8 = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(nm, q32.size() + q8.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; fails = 0; busy_cnt32 = 0; done_cnt32 = 0;
    start32 = 1'b0; op32 = 3'b000; a32 = '0; b32 = '0;
    start8  = 1'b0; op8  = 3'b000; a8  = '0; b8  = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy32}, 32'd0);
    chk("rst_done", {31'b0, done32}, 32'd0);
    chk("rst_z",    z32, 32'd0);
    chk("rst_zhi",  zhi32, 32'd0);
    chk("rst_zero", {31'b0, zero32}, 32'd1);
    chk("rst_err",  {31'b0, err32}, 32'd0);
    chk("rst_z8",   {24'b0, z8}, 32'd0);
    rst_n = 1'b1;

    issue32(3'b110, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'd0, 1'b0, 0);
    drain("drain_sub", 10);
    issue32(3'b111, 32'h8000_0000, 32'd1, 32'd1, 32'd0, 1'b0, 0);
    issue32(3'b111, 32'd1, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 0);
    issue32(3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 0);
    issue32(3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'd0, 1'b0, 0);
    issue32(3'b001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 32'd0, 1'b0, 0);
    issue32(3'b101, 32'd9, 32'd3, 32'd0, 32'd0, 1'b1, 0);
    drain("drain_1cyc", 10);

    busy_cnt32 = 0;
    issue32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 32);
    repeat (5) @(negedge clk);
    op32 = 3'b010; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(negedge clk);
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    drain("drain_mul_ff", 60);
    chk("mul_busy_cycles", busy_cnt32, 32'd32);

    issue32(3'b011, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h0000_0001, 1'b0, 32);
    drain("drain_mul2", 60);

`ifdef Y_SEQ_ALU_DIV_EN
    issue32(3'b100, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
    drain("drain_div", 60);
    issue32(3'b100, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1, 0);
    drain("drain_div0", 10);
`else
    issue32(3'b100, 32'd100, 32'd7, 32'd0, 32'd0, 1'b1, 0);
    drain("drain_divoff", 10);
`endif

    // Abort a multiply with reset on its tenth cycle.
    @(negedge clk);
    op32 = 3'b011; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy32}, 32'd0);
    chk("abort_z",    z32, 32'd0);
    chk("abort_zero", {31'b0, zero32}, 32'd1);
    chk("abort_err",  {31'b0, err32}, 32'd0);
    done_cnt32 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt32, 32'd0);
    chk("abort_idle",    {31'b0, busy32}, 32'd0);
    issue32(3'b010, 32'd20, 32'd22, 32'd42, 32'd0, 1'b0, 0);
    drain("drain_after_abort", 10);

    // Back-to-back on the 8-bit instance with start held through the done cycle.
    issue8(3'b010, 8'd3, 8'd4, 32'd7, 32'd0, 1'b0, 0, 1'b1);
    issue8(3'b011, 8'd15, 8'd17, 32'h0000_00FF, 32'd0, 1'b0, 8, 1'b0);
    drain("drain_b2b", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
